// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter with burst fairness.
// Zero-cycle grant, tagged read-return pipeline.
module data_bus_arbiter #(
  parameter int MaxBurst    = 4,
  parameter int ReadLatency = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [29:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_wr_i,
  input  logic [3:0]  m0_byte_en_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [29:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_wr_i,
  input  logic [3:0]  m1_byte_en_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [29:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        wr_o,
  output logic [3:0]  byte_en_o,
  output logic        addr_strobe_o,
  input  logic [31:0] data_i
);

  localparam int CntW = $clog2(MaxBurst + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxBurst);

  typedef enum logic [1:0] {
    OwnNone,
    OwnM0,
    OwnM1
  } owner_t;

  owner_t                 owner;
  logic                   last_winner;
  logic [CntW-1:0]        burst_cnt;
  logic [ReadLatency-1:0] tag_vld;
  logic [ReadLatency-1:0] tag_mst;

  logic win_vld;
  logic win_m;
  logic same_owner;
  logic rd_push;
  logic out_vld;

  // Winner selection: owner keeps the bus until its burst quota runs out
  always_comb begin
    win_vld = 1'b0;
    win_m   = 1'b0;
    unique case (owner)
      OwnM0: begin
        if (m0_req_i && (!m1_req_i || burst_cnt < MaxCnt)) begin
          win_vld = 1'b1;
        end else if (m1_req_i) begin
          win_vld = 1'b1;
          win_m   = 1'b1;
        end
      end
      OwnM1: begin
        if (m1_req_i && (!m0_req_i || burst_cnt < MaxCnt)) begin
          win_vld = 1'b1;
          win_m   = 1'b1;
        end else if (m0_req_i) begin
          win_vld = 1'b1;
        end
      end
      default: begin
        if (m0_req_i && m1_req_i) begin
          win_vld = 1'b1;
          win_m   = ~last_winner;
        end else if (m0_req_i) begin
          win_vld = 1'b1;
        end else if (m1_req_i) begin
          win_vld = 1'b1;
          win_m   = 1'b1;
        end
      end
    endcase
    if (rst) begin
      win_vld = 1'b0;
    end
  end

  assign same_owner = (owner == OwnM0 && !win_m) ||
                      (owner == OwnM1 && win_m);

  assign m0_gnt_o = win_vld & ~win_m;
  assign m1_gnt_o = win_vld & win_m;

  // Slave-side request mux; all zero when the bus is idle
  always_comb begin
    addr_o        = '0;
    wdata_o       = '0;
    wr_o          = 1'b0;
    byte_en_o     = '0;
    addr_strobe_o = win_vld;
    if (win_vld) begin
      addr_o    = win_m ? m1_addr_i    : m0_addr_i;
      wdata_o   = win_m ? m1_wdata_i   : m0_wdata_i;
      wr_o      = win_m ? m1_wr_i      : m0_wr_i;
      byte_en_o = win_m ? m1_byte_en_i : m0_byte_en_i;
    end
  end

  assign rd_push = win_vld & ~wr_o;

  // Read return routed by the tag leaving the pipeline
  assign out_vld     = tag_vld[ReadLatency-1] & ~rst;
  assign m0_rvalid_o = out_vld & ~tag_mst[ReadLatency-1];
  assign m1_rvalid_o = out_vld & tag_mst[ReadLatency-1];
  assign m0_rdata_o  = m0_rvalid_o ? data_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? data_i : '0;

  // Ownership, burst counting and read-tag shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OwnNone;
      last_winner <= 1'b1;
      burst_cnt   <= '0;
      tag_vld     <= '0;
      tag_mst     <= '0;
    end else begin
      if (!win_vld) begin
        owner     <= OwnNone;
        burst_cnt <= '0;
      end else begin
        owner       <= win_m ? OwnM1 : OwnM0;
        last_winner <= win_m;
        if (!same_owner) begin
          burst_cnt <= CntW'(1);
        end else if (burst_cnt != MaxCnt) begin
          burst_cnt <= burst_cnt + CntW'(1);
        end
      end
      tag_vld[0] <= rd_push;
      tag_mst[0] <= win_m;
      for (int i = 1; i < ReadLatency; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_mst[i] <= tag_mst[i-1];
      end
    end
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter MaxBurst, default 4, meaning the maximum consecutive grants to one master while the other master is requesting.
REQ-002 SHALL have parameter ReadLatency, default 1, meaning the cycles from a granted read to valid data_i (range 1-4).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have, for each master m in {m0, m1}, port m_req_i, input, 1 bit: access request.
REQ-006 SHALL have, per master, port m_addr_i, input, 30 bits: word address.
REQ-007 SHALL have, per master, port m_wdata_i, input, 32 bits: write data.
REQ-008 SHALL have, per master, port m_wr_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have, per master, port m_byte_en_i, input, 4 bits: byte lanes.
REQ-010 SHALL have, per master, port m_gnt_o, output, 1 bit: access issued this cycle.
REQ-011 SHALL have, per master, port m_rvalid_o, output, 1 bit: read data valid.
REQ-012 SHALL have, per master, port m_rdata_o, output, 32 bits: read data.
REQ-013 SHALL have slave ports addr_o (output, 30 bits), wdata_o (output, 32 bits), wr_o (output, 1 bit), byte_en_o (output, 4 bits), addr_strobe_o (output, 1 bit), and data_i (input, 32 bits): the shared data port toward the address decoder, RAM and UART.

Function
REQ-014 SHALL hold state: owner (NONE/M0/M1), last_winner (M0/M1), burst_cnt (width clog2(MaxBurst+1)), and a read-tag pipeline of ReadLatency entries {valid, master}.
REQ-015 SHALL select the winner combinationally each cycle as follows:
- Owner = Mx, mx_req_i = 1, and (other req = 0 or burst_cnt < MaxBurst): winner = Mx.
- Otherwise, if the other master requests: winner = the other master.
- Otherwise, if only one master requests: winner = that master.
- Otherwise, if both request with no owner: winner = the master that is not last_winner.
- Otherwise: winner = none.
REQ-016 SHALL assert the winner's m_gnt_o in the same cycle (zero-cycle arbitration); at most one gnt high per cycle; a master holds its request fields stable until it sees gnt.
REQ-017 SHALL drive addr_o, wdata_o, wr_o and byte_en_o from the winner when one exists, set addr_strobe_o = 1 on any grant, and drive all slave outputs to 0 with no winner.
REQ-018 SHALL update registers on each clock edge as follows:
- owner <= winner (NONE if no winner).
- last_winner <= winner if a winner exists.
- burst_cnt <= 1 when the winner differs from owner.
- burst_cnt <= min(burst_cnt+1, MaxBurst) when the winner equals owner.
- burst_cnt <= 0 with no winner.
REQ-019 SHALL push {1, winner} into the read-tag pipeline on a granted read and {0, x} otherwise; a write never produces rvalid.
REQ-020 SHALL, when the pipeline output entry is valid, assert the tagged master's m_rvalid_o for exactly 1 cycle with m_rdata_o = data_i, exactly ReadLatency cycles after its gnt.
REQ-021 SHALL hold m_rdata_o at 0 whenever its m_rvalid_o = 0.
REQ-022 SHALL support back-to-back reads from alternating masters every cycle with no bubble, each rvalid routed to the correct master.
REQ-023 SHALL treat deassertion of the owner's request as ending its tenure; the other master, if requesting, is granted in that same cycle.
REQ-024 SHALL never change burst_cnt or owner based on a request that is not granted.

Reset
REQ-025 SHALL, while rst = 1 at a clock edge, set owner = NONE, last_winner = M1 (so M0 wins the first tie), burst_cnt = 0, and all pipeline valids = 0.
REQ-026 SHALL hold all gnt, rvalid, rdata and slave outputs at 0 during the reset cycle, regardless of requests.
REQ-027 SHALL discard reads in flight at reset: no rvalid is ever produced for them after rst deasserts.

Verification
REQ-028 SHALL pass: after reset, m0 and m1 both request reads at cycle 0 -> m0_gnt at cycle 0, m1_gnt at cycle 1; m0_rvalid at cycle 1 and m1_rvalid at cycle 2 with the matching data_i (ReadLatency = 1).
REQ-029 SHALL pass: m0 and m1 both request continuously with MaxBurst = 4 -> grant pattern M0×4, M1×4, M0×4; no cycle without a grant.
REQ-030 SHALL pass: only m1 requests for 10 cycles -> m1 granted all 10 cycles (burst limit inactive); burst_cnt saturates at 4.
REQ-031 SHALL pass: m0 writes addr 0x3C00_0000, wdata 0x41, byte_en 0001 -> same-cycle addr_strobe_o = 1, wr_o = 1, byte_en_o = 0001; no m0_rvalid follows.
REQ-032 SHALL pass: m0 read granted, rst asserted the next cycle (ReadLatency = 2) -> no rvalid on either master afterward; the first post-reset tie goes to m0.
REQ-033 SHALL pass: m0 is owner with burst_cnt = 2 and drops its request while m1 requests -> m1_gnt in that same cycle, and burst_cnt = 1 at the next edge.
